// File: rtl/fp_exp_align.sv
// -----------------------------------------------------------------------------
// fp_exp_align
//
// Aligns two IEEE-754 single-precision operands for addition. The operand
// with the larger effective exponent supplies exp_big and mant_big. The other
// significand is shifted right one bit per clock until both exponents match.
// The shift distance is clamped to SHIFT_CAP bits.
//
// Configuration macro:
//   FP_ALIGN_STICKY_EN - when defined, the shifted-out bits are tracked as
//                        {guard, round, sticky} on grs. When undefined, they
//                        are discarded and grs is tied to 000. The port list
//                        and the latency are the same in both builds.
//
// Parameters:
//   SHIFT_CAP  - maximum alignment shift in bits (values below 512 supported)
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst_n      - synchronous reset, active low
//   in_valid   - an operand pair is present on a/b
//   in_ready   - high only while idle, i.e. when a pair can be accepted
//   a, b       - single-precision operands
//   out_valid  - the aligned result is valid; held until out_ready
//   out_ready  - the downstream stage takes the result
//   exp_big    - the larger effective exponent
//   mant_big   - the unshifted significand of the larger operand (hidden bit included)
//   mant_small - the right-aligned significand of the smaller operand
//   grs        - {guard, round, sticky} bits shifted out of mant_small
//   swap       - 1 when b supplied the larger exponent
// -----------------------------------------------------------------------------
module fp_exp_align #(
    parameter int SHIFT_CAP = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_big,
    output logic [23:0] mant_big,
    output logic [23:0] mant_small,
    output logic [2:0]  grs,
    output logic        swap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [8:0] CAP_EXT = 9'(SHIFT_CAP);

    state_t state_reg;
    state_t state_next;

    logic [7:0]  exp_big_reg;
    logic [23:0] mant_big_reg;
    logic [23:0] mant_small_reg;
    logic        swap_reg;
    logic [8:0]  cnt_reg;

    // The sign bits play no part in alignment.
    logic unused_sign;
    assign unused_sign = a[31] ^ b[31];

    // Denormals (exponent field 0) have hidden bit 0 and effective exponent 1.
    // Exponent 255 needs no special case and is handled as an ordinary value.
    logic        hid_a;
    logic        hid_b;
    logic [7:0]  eff_exp_a;
    logic [7:0]  eff_exp_b;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        b_gt;
    logic [8:0]  diff_ext;
    logic [8:0]  n_val;

    always_comb begin
        hid_a     = |a[30:23];
        hid_b     = |b[30:23];
        eff_exp_a = hid_a ? a[30:23] : 8'd1;
        eff_exp_b = hid_b ? b[30:23] : 8'd1;
        mant_a    = {hid_a, a[22:0]};
        mant_b    = {hid_b, b[22:0]};
        // Equal exponents keep a as the larger operand. The mantissas are not compared.
        b_gt      = eff_exp_b > eff_exp_a;
        diff_ext  = b_gt ? {1'b0, eff_exp_b - eff_exp_a} : {1'b0, eff_exp_a - eff_exp_b};
        // Beyond the cap every significand bit has already reached sticky,
        // so clamping the count does not change the result.
        n_val     = (diff_ext > CAP_EXT) ? CAP_EXT : diff_ext;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (n_val == 9'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // The counter holds the shifts still to do, including this cycle's shift.
                if (cnt_reg <= 9'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_big_reg    <= 8'd0;
            mant_big_reg   <= 24'd0;
            mant_small_reg <= 24'd0;
            swap_reg       <= 1'b0;
            cnt_reg        <= 9'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        swap_reg       <= b_gt;
                        exp_big_reg    <= b_gt ? eff_exp_b : eff_exp_a;
                        mant_big_reg   <= b_gt ? mant_b : mant_a;
                        mant_small_reg <= b_gt ? mant_a : mant_b;
                        cnt_reg        <= n_val;
                    end
                end
                SHIFT: begin
                    mant_small_reg <= mant_small_reg >> 1;
                    cnt_reg        <= cnt_reg - 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    logic g_reg;
    logic r_reg;
    logic s_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_reg <= 1'b0;
            r_reg <= 1'b0;
            s_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        g_reg <= 1'b0;
                        r_reg <= 1'b0;
                        s_reg <= 1'b0;
                    end
                end
                SHIFT: begin
                    g_reg <= mant_small_reg[0];
                    r_reg <= g_reg;
                    s_reg <= r_reg | s_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign grs = {g_reg, r_reg, s_reg};
`else
    assign grs = 3'b000;
`endif

    assign exp_big    = exp_big_reg;
    assign mant_big   = mant_big_reg;
    assign mant_small = mant_small_reg;
    assign swap       = swap_reg;

endmodule

// File: tb/tb_fp_exp_align.sv
// -----------------------------------------------------------------------------
// tb_fp_exp_align
//
// Testbench for fp_exp_align with directed vectors. The table holds operand
// pairs and the expected aligned results, all worked out by hand. Hand-written
// sequences cover backpressure in DONE and a reset that arrives mid-shift.
// The expected grs values follow FP_ALIGN_STICKY_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_fp_exp_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_big;
    logic [23:0] mant_big;
    logic [23:0] mant_small;
    logic [2:0]  grs;
    logic        swap;

    always #5 clk = ~clk;

    fp_exp_align #(.SHIFT_CAP(26)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_big    (exp_big),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .grs        (grs),
        .swap       (swap)
    );

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        swap;
        logic [7:0]  exp_big;
        logic [23:0] mant_big;
        logic [23:0] mant_small;
        logic [2:0]  grs;       // expected value when sticky tracking is enabled
        int          lat;       // cycles from the accept edge until out_valid
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " swap"},       32'(swap),       32'(v.swap));
        chk({tag, " exp_big"},    32'(exp_big),    32'(v.exp_big));
        chk({tag, " mant_big"},   32'(mant_big),   32'(v.mant_big));
        chk({tag, " mant_small"}, 32'(mant_small), 32'(v.mant_small));
        chk({tag, " grs"},        32'(grs),        STICKY ? 32'(v.grs) : 32'd0);
    endtask

    // Wait until out_valid is high. The wait is bounded; lat reports the
    // cycle count, counted from the accept edge (which gives 1).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        int    lat;
        tag = $sformatf("vec%0d", idx);
        a = v.a;
        b = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        check_outs(tag, v);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready_back"},  32'(in_ready),  32'd1);
        $display("%s a=%08h b=%08h swap=%0d exp_big=%02h mant_big=%06h mant_small=%06h grs=%03b lat=%0d",
                 tag, v.a, v.b, swap, exp_big, mant_big, mant_small, grs, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "testbench timeout");
    end

    initial begin
        int   lat;
        bit   seen;
        vec_t v;

        //            a             b             sw    exp    mant_big    mant_small  grs     lat
        vecs[0]  = '{32'h40400000, 32'h3F800000, 1'b0, 8'h80, 24'hC00000, 24'h400000, 3'b000, 2};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b1, 8'h80, 24'hC00000, 24'h400000, 3'b000, 2};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 24'h800000, 24'h800000, 3'b000, 1};
        vecs[3]  = '{32'h4B800000, 32'h3F800001, 1'b0, 8'h97, 24'h800000, 24'h000000, 3'b101, 25};
        vecs[4]  = '{32'h7F000000, 32'h3F800000, 1'b0, 8'hFE, 24'h800000, 24'h000000, 3'b001, 27};
        vecs[5]  = '{32'h4C800000, 32'h3F800000, 1'b0, 8'h99, 24'h800000, 24'h000000, 3'b001, 27};
        vecs[6]  = '{32'h7F000000, 32'h00000000, 1'b0, 8'hFE, 24'h800000, 24'h000000, 3'b000, 27};
        vecs[7]  = '{32'h00000001, 32'h00800000, 1'b0, 8'h01, 24'h000001, 24'h800000, 3'b000, 1};
        vecs[8]  = '{32'h00400003, 32'h01800000, 1'b1, 8'h03, 24'h800000, 24'h100000, 3'b110, 3};
        vecs[9]  = '{32'hFF800000, 32'h7F000000, 1'b0, 8'hFF, 24'h800000, 24'h400000, 3'b000, 2};
        vecs[10] = '{32'h41000000, 32'h3F800007, 1'b0, 8'h82, 24'h800000, 24'h100000, 3'b111, 4};

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        tick();
        tick();
        chk("rst out_valid",  32'(out_valid),  32'd0);
        chk("rst exp_big",    32'(exp_big),    32'd0);
        chk("rst mant_big",   32'(mant_big),   32'd0);
        chk("rst mant_small", 32'(mant_small), 32'd0);
        chk("rst grs",        32'(grs),        32'd0);
        chk("rst swap",       32'(swap),       32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst in_ready", 32'(in_ready), 32'd1);
        $display("reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: result held for 3 cycles while a new pair waits
        v = vecs[0];
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("hold latency", 32'(lat), 32'(v.lat));
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold in_ready",  32'(in_ready),  32'd0);
            check_outs("hold", v);
            tick();
        end
        check_outs("hold_last", v);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold taken out_valid", 32'(out_valid), 32'd0);
        chk("hold taken in_ready",  32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        chk("hold new out_valid", 32'(out_valid), 32'd1);
        check_outs("hold_new", vecs[2]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        chk("hold no double capture", 32'(seen), 32'd0);
        $display("backpressure: result held 3 cycles, new pair accepted after release");

        // Reset asserted in the middle of a shift of 20
        a = 32'h49800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("midrst busy in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst out_valid",  32'(out_valid),  32'd0);
        chk("midrst exp_big",    32'(exp_big),    32'd0);
        chk("midrst mant_big",   32'(mant_big),   32'd0);
        chk("midrst mant_small", 32'(mant_small), 32'd0);
        chk("midrst grs",        32'(grs),        32'd0);
        chk("midrst swap",       32'(swap),       32'd0);
        chk("midrst in_ready",   32'(in_ready),   32'd1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst stale out_valid", 32'(seen), 32'd0);
        $display("midshift reset: operation abandoned, no stale result");

        // The block works normally after the abandoned operation
        run_vec(vecs[10], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
